// File: rtl/adder_axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_axil_pkg
//  Description : Shared types and constants for the adder AXI4-Lite master:
//                FSM state encoding, AXI response codes and the default
//                register offsets of the adder peripheral.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_axil_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_A     = 4'd1,
        S_WR_A_B   = 4'd2,
        S_WR_B     = 4'd3,
        S_WR_B_B   = 4'd4,
        S_RD_RES   = 4'd5,
        S_RD_RES_R = 4'd6,
        S_RD_OVF   = 4'd7,
        S_RD_OVF_R = 4'd8,
        S_FIN      = 4'd9
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register offsets shared with the adder slave
    localparam int unsigned REG_OFF_A   = 0;
    localparam int unsigned REG_OFF_B   = 4;
    localparam int unsigned REG_OFF_RES = 8;
    localparam int unsigned REG_OFF_OVF = 12;

endpackage
`default_nettype wire

// File: rtl/adder_axil_master_wr_chan.sv
`default_nettype none
// ============================================================================
//  Module      : axil_wr_chan
//  Description : One AXI4-Lite write: AW and W are raised together, each held
//                with a stable payload until its own ready, then the B
//                response is awaited with bready. Reused for every write.
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_wr_chan
    import adder_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic                  addr_done,
    output logic                  resp_done,
    output logic                  resp_err
);

    // Address phase ends in the cycle the last outstanding valid handshakes
    assign addr_done = (awvalid || wvalid) &&
                       (!awvalid || awready) &&
                       (!wvalid  || wready);
    assign resp_done = bready && bvalid;
    assign resp_err  = resp_done && (bresp != RESP_OKAY);

    // Valid/ready registers; bready rises only after the address phase, so a
    // B beat arriving alongside the last handshake is consumed next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            awaddr  <= '0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else if (abort) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else if (issue) begin
            awaddr  <= wr_addr;
            wdata   <= wr_data;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            bready  <= 1'b0;
        end else begin
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;
            if (addr_done)          bready  <= 1'b1;
            else if (resp_done)     bready  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_axil_master.sv
`default_nettype none
// ============================================================================
//  Module      : adder_axil_master
//  Description : AXI4-Lite master running one add transaction per start:
//                write A, write B, read result, read overflow, then report
//                result/overflow/error with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_axil_master
    import adder_axil_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned ADDR_A     = REG_OFF_A,
    parameter int unsigned ADDR_B     = REG_OFF_B,
    parameter int unsigned ADDR_RES   = REG_OFF_RES,
    parameter int unsigned ADDR_OVF   = REG_OFF_OVF,
    parameter int          TIMEOUT    = 256
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_areset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    overflow,
    output logic                    error,
    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic [1:0]              m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic [1:0]              m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_WIDTH-1:0] A_OFF   = ADDR_WIDTH'(ADDR_A);
    localparam logic [ADDR_WIDTH-1:0] B_OFF   = ADDR_WIDTH'(ADDR_B);
    localparam logic [ADDR_WIDTH-1:0] RES_OFF = ADDR_WIDTH'(ADDR_RES);
    localparam logic [ADDR_WIDTH-1:0] OVF_OFF = ADDR_WIDTH'(ADDR_OVF);

    state_t                 state, nxt;
    logic [CNT_W-1:0]       tmo_cnt;
    logic                   tmo_hit, tmo;
    logic [DATA_WIDTH-1:0]  opb_hold, res_hold, res_nxt;
    logic                   ovf_hold, ovf_nxt, err_hold, err_nxt;
    logic                   wr_issue, wr_addr_done, wr_resp_done, wr_resp_err;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   ar_issue, ar_hs, r_hs, r_err;
    logic [ADDR_WIDTH-1:0]  ar_addr;

    assign m1_axi_wstrb = '1;
    assign busy    = (state != S_IDLE) && (state != S_FIN);
    assign done    = (state == S_FIN);
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign ar_hs   = m1_axi_arvalid && m1_axi_arready;
    assign r_hs    = m1_axi_rready && m1_axi_rvalid;
    assign r_err   = (m1_axi_rresp != RESP_OKAY);

    axil_wr_chan #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_chan (
        .clk       (m1_axi_aclk),
        .rst       (m1_axi_areset),
        .issue     (wr_issue),
        .abort     (tmo),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .awaddr    (m1_axi_awaddr),
        .awvalid   (m1_axi_awvalid),
        .awready   (m1_axi_awready),
        .wdata     (m1_axi_wdata),
        .wvalid    (m1_axi_wvalid),
        .wready    (m1_axi_wready),
        .bresp     (m1_axi_bresp),
        .bvalid    (m1_axi_bvalid),
        .bready    (m1_axi_bready),
        .addr_done (wr_addr_done),
        .resp_done (wr_resp_done),
        .resp_err  (wr_resp_err)
    );

    // State register and per-state timeout counter (cleared on every entry)
    always_ff @(posedge m1_axi_aclk) begin
        if (m1_axi_areset) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= nxt;
            tmo_cnt <= (nxt != state || state == S_IDLE) ? '0 : tmo_cnt + CNT_W'(1);
        end
    end

    // Next state, channel requests and next values of the holding registers
    always_comb begin
        nxt      = state;
        wr_issue = 1'b0;
        wr_addr  = A_OFF;
        wr_data  = op_a;
        ar_issue = 1'b0;
        ar_addr  = RES_OFF;
        tmo      = 1'b0;
        res_nxt  = res_hold;
        ovf_nxt  = ovf_hold;
        err_nxt  = err_hold;
        unique case (state)
            S_IDLE: if (start) begin
                nxt      = S_WR_A;
                wr_issue = 1'b1;
                res_nxt  = '0;
                ovf_nxt  = 1'b0;
                err_nxt  = 1'b0;
            end
            S_WR_A, S_WR_B: begin
                if (wr_addr_done) nxt = (state == S_WR_A) ? S_WR_A_B : S_WR_B_B;
                else if (tmo_hit) tmo = 1'b1;
            end
            S_WR_A_B, S_WR_B_B: begin
                if (wr_resp_done) begin
                    if (wr_resp_err) begin
                        err_nxt = 1'b1;
                        nxt     = S_FIN;
                    end else if (state == S_WR_A_B) begin
                        nxt      = S_WR_B;
                        wr_issue = 1'b1;
                        wr_addr  = B_OFF;
                        wr_data  = opb_hold;
                    end else begin
                        nxt      = S_RD_RES;
                        ar_issue = 1'b1;
                        ar_addr  = RES_OFF;
                    end
                end else if (tmo_hit) begin
                    tmo = 1'b1;
                end
            end
            S_RD_RES, S_RD_OVF: begin
                if (ar_hs) nxt = (state == S_RD_RES) ? S_RD_RES_R : S_RD_OVF_R;
                else if (tmo_hit) tmo = 1'b1;
            end
            S_RD_RES_R: begin
                if (r_hs) begin
                    res_nxt = m1_axi_rdata;
                    if (r_err) begin
                        err_nxt = 1'b1;
                        nxt     = S_FIN;
                    end else begin
                        nxt      = S_RD_OVF;
                        ar_issue = 1'b1;
                        ar_addr  = OVF_OFF;
                    end
                end else if (tmo_hit) begin
                    tmo = 1'b1;
                end
            end
            S_RD_OVF_R: begin
                if (r_hs) begin
                    ovf_nxt = m1_axi_rdata[0];
                    if (r_err) err_nxt = 1'b1;
                    nxt = S_FIN;
                end else if (tmo_hit) begin
                    tmo = 1'b1;
                end
            end
            S_FIN:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        // A timed-out transaction reports no data, only the error
        if (tmo) begin
            nxt     = S_FIN;
            err_nxt = 1'b1;
            res_nxt = '0;
            ovf_nxt = 1'b0;
        end
    end

    // Read address/data handshake registers
    always_ff @(posedge m1_axi_aclk) begin
        if (m1_axi_areset) begin
            m1_axi_araddr  <= '0;
            m1_axi_arvalid <= 1'b0;
            m1_axi_rready  <= 1'b0;
        end else if (tmo) begin
            m1_axi_arvalid <= 1'b0;
            m1_axi_rready  <= 1'b0;
        end else if (ar_issue) begin
            m1_axi_araddr  <= ar_addr;
            m1_axi_arvalid <= 1'b1;
        end else if (ar_hs) begin
            m1_axi_arvalid <= 1'b0;
            m1_axi_rready  <= 1'b1;
        end else if (r_hs) begin
            m1_axi_rready  <= 1'b0;
        end
    end

    // Holding registers and reported outputs, published on entry to FIN
    always_ff @(posedge m1_axi_aclk) begin
        if (m1_axi_areset) begin
            opb_hold <= '0;
            res_hold <= '0;
            ovf_hold <= 1'b0;
            err_hold <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            error    <= 1'b0;
        end else begin
            if (state == S_IDLE && start) opb_hold <= op_b;
            res_hold <= res_nxt;
            ovf_hold <= ovf_nxt;
            err_hold <= err_nxt;
            if (nxt == S_FIN && state != S_FIN) begin
                result   <= res_nxt;
                overflow <= ovf_nxt;
                error    <= err_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_axil_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_axil_master
//  Description : Directed self-checking bench for adder_axil_master with a
//                small behavioural adder slave and configurable stalls/errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_axil_master;
    import adder_axil_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done, overflow, error;
    logic [31:0] result;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    // Slave knobs
    int   aw_delay = 0;
    logic no_ar = 1'b0, b_err_b = 1'b0, b_stall_b = 1'b0, clr_log = 1'b0;

    int n_checks = 0, n_fail = 0;
    int lat;
    logic lat1_busy, lat1_aw;

    always #5 clk = ~clk;

    adder_axil_master #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .ADDR_A(0), .ADDR_B(4),
        .ADDR_RES(8), .ADDR_OVF(12), .TIMEOUT(256)
    ) dut (
        .m1_axi_aclk(clk), .m1_axi_areset(rst), .start(start),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .result(result), .overflow(overflow), .error(error),
        .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
        .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid),
        .m1_axi_wready(wready), .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid),
        .m1_axi_bready(bready), .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid),
        .m1_axi_arready(arready), .m1_axi_rdata(rdata), .m1_axi_rresp(rresp),
        .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
    );

    // ---------------- behavioural adder slave ----------------
    int          aw_cnt;
    logic        got_aw, got_w, stalled;
    logic [7:0]  aw_lat;
    logic [31:0] w_lat, reg_a, reg_b;
    logic [7:0]  wr_addr_log [0:7];
    logic [31:0] wr_data_log [0:7];
    logic [7:0]  ar_addr_log [0:7];
    int          wr_n, ar_n, aw_hi, w_hi, ar_hi;
    logic        aw_unstable, prev_awvalid;
    logic [7:0]  prev_awaddr;

    wire         aw_hs = awvalid && awready;
    wire         w_hs  = wvalid && wready;
    wire [7:0]   wa    = got_aw ? aw_lat : awaddr;
    wire [31:0]  wd    = got_w ? w_lat : wdata;
    wire         both  = (got_aw || aw_hs) && (got_w || w_hs);
    wire [32:0]  sum33 = {1'b0, reg_a} + {1'b0, reg_b};

    assign awready = (aw_cnt >= aw_delay);
    assign wready  = 1'b1;
    assign arready = !no_ar;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0; stalled <= 1'b0;
            bvalid <= 1'b0; bresp <= RESP_OKAY; rvalid <= 1'b0;
            rdata <= '0; rresp <= RESP_OKAY; aw_lat <= '0; w_lat <= '0;
        end else begin
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            else if (aw_hs)          aw_cnt <= 0;
            if (both && !bvalid && !(b_stall_b && wa == 8'd4)) begin
                bvalid <= 1'b1;
                bresp  <= (b_err_b && wa == 8'd4) ? RESP_SLVERR : RESP_OKAY;
                got_aw <= 1'b0;
                got_w  <= 1'b0;
                if (wa == 8'd0) reg_a <= wd;
                if (wa == 8'd4) reg_b <= wd;
                wr_addr_log[wr_n[2:0]] <= wa;
                wr_data_log[wr_n[2:0]] <= wd;
                wr_n <= wr_n + 1;
            end else begin
                if (aw_hs) begin got_aw <= 1'b1; aw_lat <= awaddr; end
                if (w_hs)  begin got_w  <= 1'b1; w_lat  <= wdata;  end
                if (both && b_stall_b && wa == 8'd4) stalled <= 1'b1;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready && !rvalid) begin
                rvalid <= 1'b1;
                rresp  <= RESP_OKAY;
                rdata  <= (araddr == 8'd8)  ? sum33[31:0] :
                          (araddr == 8'd12) ? {31'b0, sum33[32]} : 32'd0;
                ar_addr_log[ar_n[2:0]] <= araddr;
                ar_n <= ar_n + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
        // Bus monitors
        if (clr_log) begin
            wr_n <= 0; ar_n <= 0; aw_hi <= 0; w_hi <= 0; ar_hi <= 0;
            aw_unstable <= 1'b0;
        end else begin
            if (awvalid) aw_hi <= aw_hi + 1;
            if (wvalid)  w_hi  <= w_hi + 1;
            if (arvalid) ar_hi <= ar_hi + 1;
            if (awvalid && prev_awvalid && awaddr != prev_awaddr) aw_unstable <= 1'b1;
        end
        prev_awvalid <= awvalid;
        prev_awaddr  <= awaddr;
    end

    // ---------------- checking and stimulus ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        @(negedge clk); clr_log = 1'b1;
        @(negedge clk); clr_log = 1'b0;
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           input bit mid_start, output int l);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1; l = 0;
        while (!seen && l < 2000) begin
            @(negedge clk);
            l++;
            if (l == 1) begin
                start = 1'b0;
                lat1_busy = busy;
                lat1_aw   = awvalid;
            end
            if (mid_start && l == 3) begin start = 1'b1; op_a = 32'd100; op_b = 32'd100; end
            if (mid_start && l == 4) start = 1'b0;
            if (done) seen = 1'b1;
        end
        check("done_seen", {63'b0, seen}, 64'd1);
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 0);
        check("rst_done", {63'b0, done}, 0);
        check("rst_valids", {59'b0, awvalid, wvalid, bready, arvalid, rready}, 0);
        check("rst_result", {32'b0, result}, 0);
        check("rst_flags", {62'b0, overflow, error}, 0);
        rst = 1'b0;

        // T1: 5 + 7 with a zero-wait slave
        clear_log();
        run_txn(32'd5, 32'd7, 1'b0, lat);
        check("t1_lat", lat, 9);
        check("t1_busy_c1", {63'b0, lat1_busy}, 1);
        check("t1_aw_c1", {63'b0, lat1_aw}, 1);
        check("t1_result", {32'b0, result}, 12);
        check("t1_ovf_err", {62'b0, overflow, error}, 0);
        check("t1_busy_fin", {63'b0, busy}, 0);
        check("t1_wr_n", wr_n, 2);
        check("t1_wr0", {wr_addr_log[0], wr_data_log[0]}, {8'h0, 32'd5});
        check("t1_wr1", {wr_addr_log[1], wr_data_log[1]}, {8'h4, 32'd7});
        check("t1_rd", {ar_n[7:0], ar_addr_log[0], ar_addr_log[1]}, {8'd2, 8'h8, 8'hC});
        check("t1_wstrb", {60'b0, wstrb}, 64'hF);
        @(negedge clk);
        check("t1_done_pulse", {63'b0, done}, 0);
        check("t1_result_held", {32'b0, result}, 12);

        // T2: wrap-around with a start pulsed while busy
        clear_log();
        run_txn(32'hFFFF_FFFF, 32'd1, 1'b1, lat);
        check("t2_result", {32'b0, result}, 0);
        check("t2_ovf", {63'b0, overflow}, 1);
        check("t2_err", {63'b0, error}, 0);
        repeat (4) @(negedge clk);
        check("t2_no_restart", {62'b0, busy, awvalid}, 0);
        check("t2_wr_n", wr_n, 2);

        // T3: awready delayed by 3 cycles on every write
        aw_delay = 3;
        clear_log();
        run_txn(32'd3, 32'd4, 1'b0, lat);
        aw_delay = 0;
        check("t3_lat", lat, 15);
        check("t3_aw_hi", aw_hi, 8);
        check("t3_w_hi", w_hi, 2);
        check("t3_aw_stable", {63'b0, aw_unstable}, 0);
        check("t3_wr0_addr", {56'b0, wr_addr_log[0]}, 0);
        check("t3_result", {32'b0, result}, 7);
        check("t3_ovf_err", {62'b0, overflow, error}, 0);

        // T4: arready never asserted -> timeout after 256 cycles
        no_ar = 1'b1;
        clear_log();
        run_txn(32'd9, 32'd9, 1'b0, lat);
        no_ar = 1'b0;
        check("t4_ar_hi", ar_hi, 256);
        check("t4_error", {63'b0, error}, 1);
        check("t4_result", {32'b0, result}, 0);
        check("t4_ar_dropped", {63'b0, arvalid}, 0);

        // T5: SLVERR on the operand B write
        b_err_b = 1'b1;
        clear_log();
        run_txn(32'd1, 32'd2, 1'b0, lat);
        b_err_b = 1'b0;
        check("t5_lat", lat, 5);
        check("t5_no_ar", ar_hi, 0);
        check("t5_error", {63'b0, error}, 1);
        check("t5_result", {32'b0, result}, 0);

        // T6: recovery after errors
        clear_log();
        run_txn(32'd10, 32'd20, 1'b0, lat);
        check("t6_result", {32'b0, result}, 30);
        check("t6_ovf_err", {62'b0, overflow, error}, 0);

        // T7: reset while waiting in WR_B_B, with a start pulsed alongside
        b_stall_b = 1'b1;
        clear_log();
        @(negedge clk);
        op_a = 32'd6; op_b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (stalled && bready) found = 1'b1;
        end
        check("t7_reached_wrbb", {63'b0, found}, 1);
        rst = 1'b1; start = 1'b1; op_a = 32'd50;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; b_stall_b = 1'b0;
        check("t7_busy_done", {62'b0, busy, done}, 0);
        check("t7_valids", {59'b0, awvalid, wvalid, bready, arvalid, rready}, 0);
        check("t7_result", {32'b0, result}, 0);
        check("t7_addr_data", {24'b0, awaddr, wdata}, 0);
        repeat (5) @(negedge clk);
        check("t7_start_ignored", {61'b0, busy, awvalid, arvalid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_axil_master.md
Name: adder_axil_master

Overview:
- AXI4-Lite master that runs one complete add transaction against the memory-mapped adder peripheral.
- Register map of the peripheral: 0x0 operand A, 0x4 operand B, 0x8 result, 0xC overflow.
- Sequence per start pulse: write A, write B, read result, read overflow; then report result, overflow and error to local logic.
- Sits between a local command source (test controller or CPU-side sequencer) and the slave port of the adder.

Parameters:
- DATA_WIDTH, 32, data bus width; must be a multiple of 8.
- ADDR_WIDTH, 8, address bus width.
- ADDR_A, 0, operand A register address.
- ADDR_B, 4, operand B register address.
- ADDR_RES, 8, result register address.
- ADDR_OVF, 12, overflow register address.
- TIMEOUT, 256, maximum cycles to wait for any single handshake before aborting.

Ports:
- m1_axi_aclk  in  1  clock
- m1_axi_areset  in  1  reset
- start  in  1  one-cycle request; ignored while busy
- op_a  in  DATA_WIDTH  operand A, sampled on an accepted start
- op_b  in  DATA_WIDTH  operand B, sampled on an accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- result  out  DATA_WIDTH  read-back sum, held until the next done
- overflow  out  1  bit 0 of the overflow register, held until the next done
- error  out  1  non-OKAY response or timeout on this transaction, held until the next done
- m1_axi_awaddr  out  ADDR_WIDTH  write address
- m1_axi_awvalid  out  1
- m1_axi_awready  in  1
- m1_axi_wdata  out  DATA_WIDTH
- m1_axi_wstrb  out  DATA_WIDTH/8  always all ones
- m1_axi_wvalid  out  1
- m1_axi_wready  in  1
- m1_axi_bresp  in  2  00 = OKAY
- m1_axi_bvalid  in  1
- m1_axi_bready  out  1
- m1_axi_araddr  out  ADDR_WIDTH
- m1_axi_arvalid  out  1
- m1_axi_arready  in  1
- m1_axi_rdata  in  DATA_WIDTH
- m1_axi_rresp  in  2
- m1_axi_rvalid  in  1
- m1_axi_rready  out  1

Behaviour:
- Clock and reset: single clock m1_axi_aclk; reset m1_axi_areset is synchronous and active-high.
- Reset values: all valid/ready outputs, busy, done, error and overflow are 0; result is 0; addresses and data are 0; FSM is in IDLE.
- Reset mid-transaction: abort immediately; no further handshakes are completed.
- States: IDLE, WR_A, WR_A_B, WR_B, WR_B_B, RD_RES, RD_RES_R, RD_OVF, RD_OVF_R, FIN.
- IDLE: on start, latch op_a and op_b, then go to WR_A. Start in any other state is dropped.
- WR_x: awvalid and wvalid rise together with the address and data for that register.
  - Each valid stays high, with stable payload, until its own ready is sampled high.
  - AW and W may complete in the same cycle or in any order.
  - Leave the state once both have handshaken.
- WR_x_B: bready is high. On bvalid, check bresp.
  - OKAY: go to the next state.
  - Non-OKAY: set the error flag and go to FIN.
- RD_x: arvalid stays high with stable araddr until arready is seen.
- RD_x_R: rready is high.
  - On rvalid, capture rdata into a holding register (RES path) or bit 0 into the overflow holding register (OVF path).
  - rresp non-OKAY sets error and goes to FIN.
- FIN: for one cycle, done=1, busy=0, and result/overflow/error update from the holding registers. Then go to IDLE.
- Earliest start: a new start may be accepted in the cycle after FIN.
- Valid assertion: no valid output is asserted in the same cycle as an accepted start. Latency start→awvalid is 1 cycle.
- Minimum latency with zero-wait slave: start to done ≈ 9 cycles.
- Timeout: a per-state counter resets on each state entry.
  - If it reaches TIMEOUT-1 without the awaited handshake, drop all valid/ready outputs, set error, and go to FIN.
  - On a timeout, result and overflow report 0.
- Simultaneous events: bvalid/rvalid arriving in the same cycle as the handshake that requested them is legal and is consumed in the following state. No combinational paths from inputs to outputs.

Decomposition:
- Package adder_axil_pkg:
  - FSM state enum.
  - Response codes: OKAY=2'b00, SLVERR=2'b10.
  - Default register offset constants shared with the adder slave.
- Sub-module axil_wr_chan: handles independent AW/W valid-hold plus B wait for one write. It is instantiated once and reused for both operand writes.

Test Plan:
- op_a=5, op_b=7, zero-wait slave → writes 5@0x0, 7@0x4; reads 0x8 then 0xC; done with result=12, overflow=0, error=0.
- op_a=0xFFFF_FFFF, op_b=1 → result=0, overflow=1.
- Slave delays awready 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 4 cycles with stable awaddr=0x0; transaction completes correctly.
- Slave returns bresp=2'b10 on the operand B write → no AR issued; done with error=1.
- Slave never asserts arready → arvalid held 256 cycles then dropped; done with error=1, result=0.
- Reset asserted while in WR_B_B, plus a start pulsed while busy → all outputs return to reset values next cycle; the extra start has no effect.
